// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter driven by a bit-rate clock (one Div_CLK
// rising edge per bit period). Frames are start bit, DATA_W data bits sent
// LSB first, an optional odd/even parity bit, and one or two stop bits.
// A word offered during the last stop bit is accepted at once, so frames
// can run back-to-back with no idle gap.

// Structural invariants of the transmitter, kept outside the datapath.
module uart_tx_param_chk (
  input logic       Div_CLK,
  input logic       RST,
  input logic [2:0] state,
  input logic       tx,
  input logic       busy,
  input logic       ready
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;

  // The line is only ever low while a frame is in flight.
  a_idle_line_high : assert property (@(posedge Div_CLK) disable iff (RST)
    (!busy |-> tx));

  // The start bit period always drives the line low.
  a_start_low : assert property (@(posedge Div_CLK) disable iff (RST)
    ((state == ST_START) |-> !tx));

  // Idle implies the block can take a word and is not busy.
  a_idle_ready : assert property (@(posedge Div_CLK) disable iff (RST)
    ((state == ST_IDLE) |-> (ready && !busy)));

endmodule

module uart_tx_param #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              Div_CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DATA,
  input  logic              VALID,
  output logic              READY,
  output logic              TX,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // Reject configurations the frame format cannot represent.
  if ((DATA_W < 5) || (DATA_W > 9)) begin : g_bad_data_w
    $error("uart_tx_param: DATA_W must be in 5..9");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Parity bit for a captured word: odd -> XNOR-reduce, even -> XOR-reduce.
  function automatic logic parity_bit(input logic [DATA_W-1:0] word);
    logic p;
    case (PARITY)
      1:       p = ~^word;
      2:       p = ^word;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  // Stop-bit counter reload: remaining stop periods after the current one.
  localparam logic STOP_RELOAD = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] DATA_RELOAD = CNT_W'(DATA_W - 1);

  state_t            state_r,    state_nxt_s;
  logic              tx_r,       tx_nxt_s;
  logic              busy_r,     busy_nxt_s;
  logic [DATA_W-1:0] shift_r,    shift_nxt_s;
  logic [CNT_W-1:0]  cnt_r,      cnt_nxt_s;
  logic              stop_cnt_r, stop_cnt_nxt_s;
  logic              par_r,      par_nxt_s;
  logic              ready_s;
  logic              accept_s;

  // Handshake: a word is taken when idle or during the final stop period.
  always_comb begin
    ready_s  = 1'b0;
    accept_s = 1'b0;
    if ((state_r == S_IDLE) || ((state_r == S_STOP) && (stop_cnt_r == 1'b0))) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    accept_s = VALID & ready_s;
  end

  // Next-state and next-output logic; TX holds the value of the current bit period.
  always_comb begin
    state_nxt_s    = state_r;
    tx_nxt_s       = tx_r;
    busy_nxt_s     = busy_r;
    shift_nxt_s    = shift_r;
    cnt_nxt_s      = cnt_r;
    stop_cnt_nxt_s = stop_cnt_r;
    par_nxt_s      = par_r;

    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = S_START;
          tx_nxt_s    = 1'b0;
          busy_nxt_s  = 1'b1;
          shift_nxt_s = DATA;
          par_nxt_s   = parity_bit(DATA);
        end else begin
          tx_nxt_s    = 1'b1;
          busy_nxt_s  = 1'b0;
        end
      end

      S_START: begin
        state_nxt_s = S_DATA;
        tx_nxt_s    = shift_r[0];
        shift_nxt_s = {1'b0, shift_r[DATA_W-1:1]};
        cnt_nxt_s   = DATA_RELOAD;
      end

      S_DATA: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          tx_nxt_s    = shift_r[0];
          shift_nxt_s = {1'b0, shift_r[DATA_W-1:1]};
          cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (PARITY != 0) begin
          state_nxt_s = S_PAR;
          tx_nxt_s    = par_r;
        end else begin
          state_nxt_s    = S_STOP;
          tx_nxt_s       = 1'b1;
          stop_cnt_nxt_s = STOP_RELOAD;
        end
      end

      S_PAR: begin
        state_nxt_s    = S_STOP;
        tx_nxt_s       = 1'b1;
        stop_cnt_nxt_s = STOP_RELOAD;
      end

      S_STOP: begin
        if (stop_cnt_r != 1'b0) begin
          stop_cnt_nxt_s = 1'b0;
          tx_nxt_s       = 1'b1;
        end else if (accept_s) begin
          // Back-to-back frame: start bit follows the stop bit directly.
          state_nxt_s = S_START;
          tx_nxt_s    = 1'b0;
          busy_nxt_s  = 1'b1;
          shift_nxt_s = DATA;
          par_nxt_s   = parity_bit(DATA);
        end else begin
          state_nxt_s = S_IDLE;
          tx_nxt_s    = 1'b1;
          busy_nxt_s  = 1'b0;
        end
      end

      default: begin
        state_nxt_s    = S_IDLE;
        tx_nxt_s       = 1'b1;
        busy_nxt_s     = 1'b0;
        shift_nxt_s    = {DATA_W{1'b0}};
        cnt_nxt_s      = {CNT_W{1'b0}};
        stop_cnt_nxt_s = 1'b0;
        par_nxt_s      = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame immediately.
  always_ff @(posedge Div_CLK or posedge RST) begin
    if (RST) begin
      state_r    <= S_IDLE;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      shift_r    <= {DATA_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      stop_cnt_r <= 1'b0;
      par_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tx_r       <= tx_nxt_s;
      busy_r     <= busy_nxt_s;
      shift_r    <= shift_nxt_s;
      cnt_r      <= cnt_nxt_s;
      stop_cnt_r <= stop_cnt_nxt_s;
      par_r      <= par_nxt_s;
    end
  end

  assign READY = ready_s;
  assign TX    = tx_r;
  assign BUSY  = busy_r;

  uart_tx_param_chk u_chk (
    .Div_CLK (Div_CLK),
    .RST     (RST),
    .state   (state_r),
    .tx      (tx_r),
    .busy    (busy_r),
    .ready   (ready_s)
  );

endmodule
